// File: rtl/branch_queue_pkg.sv
// Shared widths and the in-flight branch record used by the branch queue and its storage.
package branch_queue_pkg;

  localparam int unsigned PATTERN_WIDTH  = 10;
  localparam int unsigned INST_MEM_WIDTH = 14;

  typedef struct packed {
    logic [PATTERN_WIDTH-1:0]  pattern;
    logic [1:0]                prediction;
    logic [INST_MEM_WIDTH-1:0] alt_addr;
  } bq_entry_t;

  // The MSB of the 2-bit counter is the predicted direction.
  function automatic logic mispredicted(input logic [1:0] prediction, input logic taken);
    return taken ^ prediction[1];
  endfunction

endpackage

// File: rtl/bq_storage.sv
// Entry array for the branch queue: synchronous write at tail, asynchronous read at head.
module bq_storage
  import branch_queue_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             write_en,
  input  logic [PTR_W-1:0] write_addr,
  input  bq_entry_t        write_data,
  input  logic [PTR_W-1:0] read_addr,
  output bq_entry_t        read_data
);

  bq_entry_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (write_en) mem[write_addr] <= write_data;
  end

  assign read_data = mem[read_addr];

endmodule

// File: rtl/branch_queue.sv
// In-order queue of in-flight conditional branches; retires the oldest on resolve and
// produces the registered commit/feedback bundle for the fetch stage.
module branch_queue
  import branch_queue_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      push,
  input  logic [PATTERN_WIDTH-1:0]  push_pattern,
  input  logic [1:0]                push_prediction,
  input  logic [INST_MEM_WIDTH-1:0] push_alt_addr,
  output logic                      full,
  input  logic                      resolve,
  input  logic                      resolve_taken,
  input  logic                      flush,
  output logic                      commit_b,
  output logic                      failure,
  output logic [PATTERN_WIDTH-1:0]  pattern_end,
  output logic [1:0]                prediction_end,
  output logic [INST_MEM_WIDTH-1:0] addr_on_failure,
  output logic [CNT_W-1:0]          count
);

  logic [PTR_W-1:0] head, tail, head_next, tail_next;
  logic [CNT_W-1:0] count_next;
  logic             push_acc, resolve_acc, fail;
  bq_entry_t        head_entry, push_entry;

  assign full        = (count == CNT_W'(DEPTH));
  assign resolve_acc = resolve && (count != '0);
  assign fail        = resolve_acc && mispredicted(head_entry.prediction, resolve_taken);
  // A push alongside a mispredict or flush is wrong-path and never written.
  assign push_acc    = push && !full && !fail && !flush;

  always_comb begin
    push_entry            = '0;
    push_entry.pattern    = push_pattern;
    push_entry.prediction = push_prediction;
    push_entry.alt_addr   = push_alt_addr;
  end

  bq_storage #(.DEPTH(DEPTH)) u_storage (
    .clk        (clk),
    .write_en   (push_acc),
    .write_addr (tail),
    .write_data (push_entry),
    .read_addr  (head),
    .read_data  (head_entry)
  );

  always_comb begin
    head_next  = head + PTR_W'(resolve_acc);
    tail_next  = tail + PTR_W'(push_acc);
    count_next = count + CNT_W'(push_acc) - CNT_W'(resolve_acc);
    if (flush) begin
      head_next  = '0;
      tail_next  = '0;
      count_next = '0;
    end else if (fail) begin
      tail_next  = head + PTR_W'(1);
      count_next = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head_next;
      tail  <= tail_next;
      count <= count_next;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      commit_b        <= 1'b0;
      failure         <= 1'b0;
      pattern_end     <= '0;
      prediction_end  <= '0;
      addr_on_failure <= '0;
    end else begin
      commit_b <= resolve_acc;
      failure  <= fail;
      if (resolve_acc) begin
        pattern_end     <= head_entry.pattern;
        prediction_end  <= head_entry.prediction;
        addr_on_failure <= head_entry.alt_addr;
      end
    end
  end

  push_while_full: assert property (@(posedge clk) disable iff (!reset_n) !(push && full))
    else $warning("branch_queue: push while full dropped");

  resolve_while_empty: assert property (@(posedge clk) disable iff (!reset_n) !(resolve && count == '0))
    else $warning("branch_queue: resolve while empty ignored");

endmodule

// File: tb/tb_branch_queue.sv
// Directed bench for branch_queue: stimulus queues expected commits, a monitor checks them.
module tb_branch_queue;
  import branch_queue_pkg::*;

  localparam int unsigned DEPTH = 4;

  logic                      clk = 1'b0;
  logic                      reset_n = 1'b0;
  logic                      push = 1'b0;
  logic [PATTERN_WIDTH-1:0]  push_pattern = '0;
  logic [1:0]                push_prediction = '0;
  logic [INST_MEM_WIDTH-1:0] push_alt_addr = '0;
  logic                      full;
  logic                      resolve = 1'b0;
  logic                      resolve_taken = 1'b0;
  logic                      flush = 1'b0;
  logic                      commit_b;
  logic                      failure;
  logic [PATTERN_WIDTH-1:0]  pattern_end;
  logic [1:0]                prediction_end;
  logic [INST_MEM_WIDTH-1:0] addr_on_failure;
  logic [$clog2(DEPTH):0]    count;

  branch_queue #(.DEPTH(DEPTH)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .push            (push),
    .push_pattern    (push_pattern),
    .push_prediction (push_prediction),
    .push_alt_addr   (push_alt_addr),
    .full            (full),
    .resolve         (resolve),
    .resolve_taken   (resolve_taken),
    .flush           (flush),
    .commit_b        (commit_b),
    .failure         (failure),
    .pattern_end     (pattern_end),
    .prediction_end  (prediction_end),
    .addr_on_failure (addr_on_failure),
    .count           (count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [PATTERN_WIDTH-1:0]  pat;
    logic [1:0]                pred;
    logic                      fail;
    logic [INST_MEM_WIDTH-1:0] alt;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   compared = 0;
  int   mismatched = 0;

  always @(negedge clk) begin
    if (reset_n) begin
      compared++;
      if (commit_b) begin
        if (exp_q.size() == 0) begin
          mismatched++;
          $display("FAIL commit_unexpected: got commit_b=1 pattern_end=%h, required no commit", pattern_end);
        end else begin
          mon_e = exp_q.pop_front();
          if ({failure, pattern_end, prediction_end, addr_on_failure} !==
              {mon_e.fail, mon_e.pat, mon_e.pred, mon_e.alt}) begin
            mismatched++;
            $display("FAIL commit_bundle: got fail=%b pat=%h pred=%b alt=%h, required fail=%b pat=%h pred=%b alt=%h",
                     failure, pattern_end, prediction_end, addr_on_failure,
                     mon_e.fail, mon_e.pat, mon_e.pred, mon_e.alt);
          end
        end
      end else if (failure !== 1'b0) begin
        mismatched++;
        $display("FAIL failure_idle: got failure=%b without commit, required 0", failure);
      end
    end
  end

  task automatic check(input string name, input int act, input int req);
    compared++;
    if (act != req) begin
      mismatched++;
      $display("FAIL %s: got %0d (0x%h), required %0d (0x%h)", name, act, act, req, req);
    end
  endtask

  task automatic cyc(input logic p, input logic [PATTERN_WIDTH-1:0] pat, input logic [1:0] pr,
                     input logic [INST_MEM_WIDTH-1:0] alt, input logic r, input logic t, input logic f);
    push = p; push_pattern = pat; push_prediction = pr; push_alt_addr = alt;
    resolve = r; resolve_taken = t; flush = f;
    @(posedge clk);
    #1;
    push = 1'b0; resolve = 1'b0; resolve_taken = 1'b0; flush = 1'b0;
  endtask

  task automatic do_push(input logic [PATTERN_WIDTH-1:0] pat, input logic [1:0] pr,
                         input logic [INST_MEM_WIDTH-1:0] alt);
    cyc(1'b1, pat, pr, alt, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_resolve(input logic t);
    cyc(1'b0, '0, '0, '0, 1'b1, t, 1'b0);
  endtask

  task automatic idle();
    cyc(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic expect_commit(input logic [PATTERN_WIDTH-1:0] pat, input logic [1:0] pred,
                               input logic fail, input logic [INST_MEM_WIDTH-1:0] alt);
    exp_t e;
    e.pat = pat; e.pred = pred; e.fail = fail; e.alt = alt;
    exp_q.push_back(e);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_count", int'(count), 0);
    check("rst_full", int'(full), 0);
    check("rst_outputs", int'({commit_b, failure, pattern_end, prediction_end, addr_on_failure}), 0);
    reset_n = 1'b1;
    idle();

    // Asynchronous reset in the middle of operation
    do_push(10'h0a1, 2'b11, 14'h0111);
    do_push(10'h0a2, 2'b11, 14'h0112);
    do_push(10'h0a3, 2'b11, 14'h0113);
    expect_commit(10'h0a1, 2'b11, 1'b0, 14'h0111);
    do_resolve(1'b1);
    idle();
    check("pre_rst_pattern", int'(pattern_end), 'h0a1);
    check("pre_rst_count", int'(count), 2);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_count", int'(count), 0);
    check("async_rst_full", int'(full), 0);
    check("async_rst_pattern", int'(pattern_end), 0);
    check("async_rst_pred", int'(prediction_end), 0);
    check("async_rst_addr", int'(addr_on_failure), 0);
    check("async_rst_commit", int'({commit_b, failure}), 0);
    @(posedge clk);
    #3 reset_n = 1'b1;
    @(posedge clk);
    #1;
    do_resolve(1'b1);
    check("post_rst_empty_resolve", int'(count), 0);
    idle();

    // Fill to DEPTH, drop the extra push, then drain in order
    for (int i = 0; i < 4; i++) do_push(10'(32'h011 * (i + 1)), 2'b11, 14'(32'h1000 + i));
    check("fill_count", int'(count), 4);
    check("fill_full", int'(full), 1);
    do_push(10'h055, 2'b11, 14'h1004);
    check("overfill_count", int'(count), 4);
    check("overfill_full", int'(full), 1);
    for (int i = 0; i < 4; i++) begin
      expect_commit(10'(32'h011 * (i + 1)), 2'b11, 1'b0, 14'(32'h1000 + i));
      do_resolve(1'b1);
    end
    check("drain_count", int'(count), 0);
    check("drain_full", int'(full), 0);
    idle();

    // Mispredict discards younger entries
    do_push(10'h100, 2'b10, 14'h0200);
    do_push(10'h101, 2'b01, 14'h0201);
    do_push(10'h102, 2'b11, 14'h0202);
    check("mp_count_before", int'(count), 3);
    expect_commit(10'h100, 2'b10, 1'b1, 14'h0200);
    do_resolve(1'b0);
    check("mp_count_after", int'(count), 0);
    do_resolve(1'b1);
    check("mp_resolve_ignored", int'(count), 0);
    idle();

    // Push + correct resolve at count=2, then push + mispredict at count=2
    do_push(10'h0d1, 2'b11, 14'h0300);
    do_push(10'h0e1, 2'b00, 14'h0301);
    expect_commit(10'h0d1, 2'b11, 1'b0, 14'h0300);
    cyc(1'b1, 10'h0f1, 2'b11, 14'h0302, 1'b1, 1'b1, 1'b0);
    check("simul_ok_count", int'(count), 2);
    expect_commit(10'h0e1, 2'b00, 1'b1, 14'h0301);
    cyc(1'b1, 10'h0a7, 2'b11, 14'h0303, 1'b1, 1'b1, 1'b0);
    check("simul_mp_count", int'(count), 0);
    do_push(10'h0b8, 2'b11, 14'h0304);
    check("simul_mp_refill", int'(count), 1);
    expect_commit(10'h0b8, 2'b11, 1'b0, 14'h0304);
    do_resolve(1'b1);
    idle();

    // Wrap-around: 3*DEPTH overlapped push/resolve pairs
    do_push(10'h200, 2'b01, 14'h0400);
    for (int i = 0; i < 3 * DEPTH; i++) begin
      expect_commit(10'(32'h200 + i), (i % 2 == 1) ? 2'b11 : 2'b01, 1'b0, 14'(32'h0400 + i));
      if (i < 3 * DEPTH - 1)
        cyc(1'b1, 10'(32'h200 + i + 1), ((i + 1) % 2 == 1) ? 2'b11 : 2'b01, 14'(32'h0400 + i + 1),
            1'b1, logic'(i % 2), 1'b0);
      else
        cyc(1'b0, '0, '0, '0, 1'b1, logic'(i % 2), 1'b0);
      check("wrap_count", int'(count), (i < 3 * DEPTH - 1) ? 1 : 0);
    end
    idle();

    // Flush with a same-cycle resolve still retires the older branch
    do_push(10'h3c1, 2'b11, 14'h0500);
    do_push(10'h3c2, 2'b11, 14'h0501);
    expect_commit(10'h3c1, 2'b11, 1'b0, 14'h0500);
    cyc(1'b1, 10'h3c3, 2'b11, 14'h0502, 1'b1, 1'b1, 1'b1);
    check("flush_count", int'(count), 0);
    check("flush_full", int'(full), 0);
    do_resolve(1'b1);
    check("flush_resolve_ignored", int'(count), 0);
    do_push(10'h3d4, 2'b10, 14'h0503);
    expect_commit(10'h3d4, 2'b10, 1'b0, 14'h0503);
    do_resolve(1'b1);
    repeat (3) idle();

    check("pending_commits", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
